// File: rtl/demux1x3_pkg.sv
// Shared types and constants for the 1-to-3 serial demultiplexer.
// Build option: define DEMUX1X3_PARITY_EN to add a fourth (even-parity) slot
// to every frame.
package demux1x3_pkg;

  // Number of data bits reassembled per frame.
  localparam int DATA_W = 3;

  // Width of the slot index driven to the upstream mux select.
  localparam int SLOT_W = 2;

`ifdef DEMUX1X3_PARITY_EN
  // Three data slots followed by one even-parity slot.
  localparam int SLOT_COUNT = 4;
`else
  // Three data slots, no parity slot.
  localparam int SLOT_COUNT = 3;
`endif

  // Frame capture states; SLOT3 exists only when the parity slot is built.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SLOT0 = 3'd1,
    SLOT1 = 3'd2,
    SLOT2 = 3'd3
`ifdef DEMUX1X3_PARITY_EN
    ,
    SLOT3 = 3'd4
`endif
  } state_t;

`ifdef DEMUX1X3_PARITY_EN
  localparam state_t LAST_SLOT = SLOT3;
`else
  localparam state_t LAST_SLOT = SLOT2;
`endif

  // Slot index presented on sel for a given state; IDLE parks the mux on 0.
  function automatic logic [SLOT_W-1:0] slot_index(input state_t s);
    logic [SLOT_W-1:0] idx;
    idx = '0;
    case (s)
      SLOT0:   idx = 2'd0;
      SLOT1:   idx = 2'd1;
      SLOT2:   idx = 2'd2;
`ifdef DEMUX1X3_PARITY_EN
      SLOT3:   idx = 2'd3;
`endif
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Even-parity bit: the value that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/demux1x3_fsm.sv
// Slot sequencer for demux1x3: walks IDLE -> SLOT0..SLOTn, drives the upstream
// mux select, a per-slot sample strobe and a one-cycle frame_done pulse.
// Build option: DEMUX1X3_PARITY_EN adds SLOT3 (see demux1x3_pkg).
//
// frame_done is registered: it is high during the cycle after the last slot
// was sampled, so the holding register loads on the following edge. This is
// what puts the word on the outputs SLOT_COUNT+1 edges after the start edge.
module demux1x3_fsm
  import demux1x3_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [SLOT_W-1:0] sel,
  output logic              busy,
  output logic              sample,
  output logic              frame_done,
  output state_t            state_dbg
);

  state_t state;
  state_t state_next;
  logic   last_slot;

  // State register; reset drops any partial frame back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start only matters in IDLE and in the last slot.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SLOT0;
      SLOT0:   state_next = SLOT1;
      SLOT1:   state_next = SLOT2;
`ifdef DEMUX1X3_PARITY_EN
      SLOT2:   state_next = SLOT3;
      SLOT3:   state_next = start ? SLOT0 : IDLE;
`else
      SLOT2:   state_next = start ? SLOT0 : IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  assign sel       = slot_index(state);
  assign busy      = (state != IDLE);
  assign sample    = (state != IDLE);
  assign last_slot = (state == LAST_SLOT);
  assign state_dbg = state;

  // Completion pulse, one cycle after the last slot bit was captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_slot;
    end
  end

endmodule

// File: rtl/demux1x3.sv
// 1-to-3 serial demultiplexer: steers an upstream mux3x1 through its slots,
// reassembles the serial bits into a 3-bit word and presents it with a
// valid/ready output handshake, a sticky overrun flag and optional parity check.
// Build option: DEMUX1X3_PARITY_EN adds a 4th slot carrying an even-parity
// bit; parity_err is then loaded alongside out, otherwise it is tied low.
//
// Output handshake: out/out_valid form a valid/ready pair. A word transfers on
// a rising edge where out_valid && out_ready. While out_valid=1 and
// out_ready=0 the word is held stable; a frame completing then is dropped and
// sets overrun, which only reset clears. A completion in the same cycle as a
// transfer replaces the word without a bubble.
module demux1x3
  import demux1x3_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in,
  output logic [SLOT_W-1:0] sel,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun,
  output logic              parity_err
);

  logic                  sample;
  logic                  frame_done;
  state_t                fsm_state;
  logic [SLOT_COUNT-1:0] slot_reg;
  logic [DATA_W-1:0]     word;
  logic                  load;
  logic                  drop;

  demux1x3_fsm u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .sel        (sel),
    .busy       (busy),
    .sample     (sample),
    .frame_done (frame_done),
    .state_dbg  (fsm_state)
  );

  // Slot register: capture in at the edge ending each slot. In IDLE the
  // completed word (if any) is read by the holding register on this same edge,
  // so clearing here only discards stale bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg <= '0;
    end else if (sample) begin
      slot_reg[sel] <= in;
    end else if (fsm_state == IDLE) begin
      slot_reg <= '0;
    end
  end

  // Slot-to-bit mapping: LSB_FIRST puts slot 0 in out[0], else in out[DATA_W-1].
  always_comb begin
    word = '0;
    for (int i = 0; i < DATA_W; i++) begin
      word[i] = LSB_FIRST ? slot_reg[i] : slot_reg[DATA_W-1-i];
    end
  end

  assign load = frame_done && (!out_valid || out_ready);
  assign drop = frame_done && out_valid && !out_ready;

  // Holding register and valid flag for the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out       <= word;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overrun: set when a completed word finds the holder still full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

`ifdef DEMUX1X3_PARITY_EN
  logic parity_bad;
  logic parity_q;

  // Received parity bit sits in the last slot; parity is order independent.
  assign parity_bad = slot_reg[SLOT_COUNT-1] ^ even_parity(slot_reg[DATA_W-1:0]);

  // Parity status travels with the word it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= parity_bad;
    end
  end

  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux1x3.sv
// Bench for demux1x3: models the upstream mux3x1 from sel, pushes expected
// words (with expected parity status) when frames are launched and pops them
// whenever the DUT hands a word over on out_valid && out_ready.
module tb_demux1x3;
  import demux1x3_pkg::*;

`ifdef DEMUX1X3_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_bit;
  logic [1:0] sel;
  logic [2:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       overrun;
  logic       parity_err;

  logic [2:0] cur_word = 3'b000;
  logic       cur_pbit = 1'b0;
  logic [3:0] frame_bits;
  logic [3:0] mon_exp;

  logic [3:0] exp_q[$];
  int         acc_cyc[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;

  demux1x3 #(.LSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in         (in_bit),
    .sel        (sel),
    .out        (out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Upstream mux3x1 (plus parity bit in slot 3).
  always_comb begin
    frame_bits = {cur_pbit, cur_word};
    in_bit     = frame_bits[sel];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] expect_word(input logic [2:0] w, input logic p);
    logic perr;
    perr = PAR_EN ? (p ^ (^w)) : 1'b0;
    return {perr, w};
  endfunction

  // Scoreboard: every handshake transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("sb_word", {parity_err, out}, mon_exp);
        acc_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise start for one edge, then present the frame bits to the mux model.
  task automatic start_frame(input logic [2:0] w, input logic p, input bit keep);
    start = 1'b1;
    tick();
    start     = 1'b0;
    cur_word  = w;
    cur_pbit  = p;
    if (keep) exp_q.push_back(expect_word(w, p));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"}, sel, 0);
    check({tag, "_out"}, out, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ovr"}, overrun, 0);
    check({tag, "_perr"}, parity_err, 0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Single frame 010: sel walk, latency, parity_err low.
    start_frame(3'b010, 1'b1, 1'b1);
    for (int i = 0; i < SLOT_COUNT; i++) begin
      check("s1_sel", sel, i);
      check("s1_busy", busy, 1);
      tick();
    end
    check("s1_idle_busy", busy, 0);
    check("s1_early_valid", out_valid, 0);
    tick();
    check("s1_valid", out_valid, 1);
    check("s1_out", out, 3'b010);
    check("s1_perr", parity_err, 0);
    out_ready = 1'b1;
    tick();
    check("s1_clear", out_valid, 0);

    // Back-to-back frames with out_ready held high.
    acc_cyc.delete();
    start_frame(3'b101, 1'b0, 1'b1);
    for (int i = 0; i < SLOT_COUNT - 1; i++) begin
      check("s2_busy_a", busy, 1);
      tick();
    end
    start_frame(3'b010, 1'b1, 1'b1);
    for (int i = 0; i < SLOT_COUNT; i++) begin
      check("s2_busy_b", busy, 1);
      tick();
    end
    tick();
    tick();
    check("s2_count", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) check("s2_gap", acc_cyc[1] - acc_cyc[0], SLOT_COUNT);
    check("s2_ovr", overrun, 0);

    // Overrun: second word dropped while the first is held.
    out_ready = 1'b0;
    start_frame(3'b011, 1'b0, 1'b1);
    repeat (SLOT_COUNT + 1) tick();
    check("s3_out_a", out, 3'b011);
    check("s3_ovr_a", overrun, 0);
    start_frame(3'b100, 1'b1, 1'b0);
    repeat (SLOT_COUNT + 1) tick();
    check("s3_out_hold", out, 3'b011);
    check("s3_valid", out_valid, 1);
    check("s3_ovr", overrun, 1);
    out_ready = 1'b1;
    tick();
    check("s3_clear", out_valid, 0);
    check("s3_ovr_sticky", overrun, 1);
    out_ready = 1'b0;

    // Asynchronous reset in SLOT1, then a clean frame 111.
    start_frame(3'b110, 1'b0, 1'b0);
    tick();
    check("s4_sel1", sel, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("s4_rst");
    @(negedge clk);
    #1 rst_n = 1'b1;
    start_frame(3'b111, 1'b1, 1'b1);
    check("s4_busy", busy, 1);
    check("s4_sel0", sel, 0);
    repeat (SLOT_COUNT + 1) tick();
    check("s4_out", out, 3'b111);
    check("s4_valid", out_valid, 1);
    check("s4_ovr", overrun, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

`ifdef DEMUX1X3_PARITY_EN
    // Parity: 110 with correct bit 0, then with wrong bit 1.
    start_frame(3'b110, 1'b0, 1'b1);
    repeat (3) tick();
    check("p_sel3", sel, 3);
    repeat (2) tick();
    check("p_out_ok", out, 3'b110);
    check("p_perr_ok", parity_err, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start_frame(3'b110, 1'b1, 1'b1);
    repeat (5) tick();
    check("p_out_bad", out, 3'b110);
    check("p_valid_bad", out_valid, 1);
    check("p_perr_bad", parity_err, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif

    tick();
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux1x3.md
DEMUX1X3 -- requirements
Module: demux1x3

Interface
REQ-001 Parameter: LSB_FIRST, default 1; 1 = slot 0 lands in out[0], 0 = slot 0 lands in out[2].
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  frame-start request, sampled on clk.
REQ-005 Port: in  input  1  serial bit from the upstream mux3x1 output.
REQ-006 Port: sel  output  2  current slot index, driven to the upstream mux3x1 select.
REQ-007 Port: out  output  3  reassembled parallel word.
REQ-008 Port: out_valid  output  1  out holds an unaccepted word.
REQ-009 Port: out_ready  input  1  consumer accepts the word.
REQ-010 Port: busy  output  1  frame capture in progress.
REQ-011 Port: overrun  output  1  sticky flag: a completed frame was dropped.
REQ-012 Port: parity_err  output  1  parity mismatch on the held word.

Function
REQ-013 The FSM SHALL have states IDLE, SLOT0, SLOT1, SLOT2 and, with parity enabled, SLOT3.
REQ-014 sel SHALL decode combinationally from state: SLOTn gives n; IDLE gives 2'b00.
REQ-015 IDLE SHALL go to SLOT0 on the edge where start=1; SLOTn SHALL advance to SLOTn+1 unconditionally.
REQ-016 in SHALL be sampled into a shift/slot register at the clock edge that ends each SLOTn cycle.
REQ-017 From the last slot, the FSM SHALL go to SLOT0 if start=1 on that edge (back-to-back frames, no gap), else to IDLE.
REQ-018 start SHALL be ignored in every state except IDLE and the last slot.
REQ-019 busy SHALL be 1 in every SLOTn state and 0 in IDLE.
REQ-020 Latency: with start high at edge N and no parity, slots occupy cycles N+1..N+3, and out/out_valid SHALL update at edge N+4.
REQ-021 Word completion with out_valid=0, or with out_valid=1 and out_ready=1 in the same cycle, SHALL load out and set out_valid=1.
REQ-022 Word completion with out_valid=1 and out_ready=0 SHALL drop the new word, keep out unchanged and set overrun=1.
REQ-023 out_valid SHALL clear on out_valid&&out_ready when no word completes in that cycle.
REQ-024 out SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 overrun SHALL clear only on reset.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately force the state to IDLE, sel=0, out=3'b000, out_valid=0, busy=0, overrun=0 and parity_err=0, including mid-frame; a partial frame is discarded.
REQ-027 After rst_n deassertion, the first start SHALL be honoured on the next clock edge.

Configuration
REQ-028 With macro DEMUX1X3_PARITY_EN defined, frames SHALL have 4 slots, and SLOT3 (sel=2'b11) SHALL sample an even-parity bit over the 3 data bits.
REQ-029 With parity enabled, parity_err SHALL load together with out: 1 on mismatch, and the word is still delivered.
REQ-030 With parity enabled, latency from start SHALL be 5 cycles.
REQ-031 Without DEMUX1X3_PARITY_EN, frames SHALL have 3 slots, SLOT3 SHALL be absent, and parity_err SHALL be tied to 0.

Structure
REQ-032 Package demux1x3_pkg SHALL hold the state enum, the SLOT_COUNT constant (3 or 4, depending on the macro) and the slot-index width.
REQ-033 The FSM and slot decode SHALL be a sub-module, demux1x3_fsm (outputs: sel, busy, sample strobe, frame_done); the output holding register and handshake stay in the top level.

Verification
REQ-034 Scenario: LSB_FIRST=1, start pulse, in driven by mux3x1 with in=3'b010 -> out=3'b010 and out_valid=1 at start edge +4, with sel sequence 00,01,10.
REQ-035 Scenario: out_ready held 1, two back-to-back frames 3'b101 then 3'b010 with start high in SLOT2 -> outputs 101 then 010, three cycles apart, busy never drops.
REQ-036 Scenario: out_ready=0, two frames complete -> out stays at the first word, overrun=1; out_ready=1 then clears out_valid, and overrun stays 1.
REQ-037 Scenario: rst_n pulsed low during SLOT1 -> all outputs return to zero at once; the next frame 3'b111 is captured correctly.
REQ-038 Scenario (DEMUX1X3_PARITY_EN): data 3'b110 with parity bit 0 gives parity_err=0; with parity bit 1 gives parity_err=1; sel reaches 2'b11.
